// File: rtl/fact_cu.sv
// fact_cu: Moore control unit for the factorial datapath.
// Sequences the datapath through INIT / CHECK / MUL to compute N!, and
// reports completion or an out-of-range rejection through a level
// handshake on go/done.
// Optional feature: define FACT_CU_CYCLE_CNT_EN to add an 8-bit busy-cycle
// counter output `cycles`.
module fact_cu (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       GT_flag,
  input  logic       Err,
  output logic       sel1,
  output logic       sel2,
  output logic       reg_load,
  output logic       cnt_load,
  output logic       cnt_en,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef FACT_CU_CYCLE_CNT_EN
  ,
  output logic [7:0] cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_MUL   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t state_q, state_d;

  // State register; reset always lands in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; go only matters in IDLE, DONE and ERR. Unused codes recover to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (go && Err)       state_d = S_ERR;
        else if (go)         state_d = S_INIT;
        else                 state_d = S_IDLE;
      end
      S_INIT:                state_d = S_CHECK;
      S_CHECK:               state_d = GT_flag ? S_MUL : S_DONE;
      S_MUL:                 state_d = S_CHECK;
      S_DONE:                state_d = go ? S_DONE : S_IDLE;
      S_ERR:                 state_d = go ? S_ERR : S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Output decode from the state register only, so no input-to-output path exists.
  always_comb begin
    sel1     = 1'b0;
    sel2     = 1'b1;
    reg_load = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_INIT: begin
        sel1     = 1'b1;
        reg_load = 1'b1;
        cnt_load = 1'b1;
        busy     = 1'b1;
      end
      S_CHECK: begin
        busy     = 1'b1;
      end
      S_MUL: begin
        reg_load = 1'b1;
        cnt_en   = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        sel2     = 1'b0;
        done     = 1'b1;
      end
      S_ERR: begin
        done     = 1'b1;
        err      = 1'b1;
      end
      default: begin
        sel2     = 1'b1;
      end
    endcase
  end

`ifdef FACT_CU_CYCLE_CNT_EN
  logic [7:0] cycles_q;
  logic       accept;

  assign accept = (state_q == S_IDLE) && go;

  // Busy-cycle counter: cleared when a request is accepted, counts busy edges, saturates at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q <= 8'd0;
    end else if (accept) begin
      cycles_q <= 8'd0;
    end else if (busy && (cycles_q != 8'hFF)) begin
      cycles_q <= cycles_q + 8'd1;
    end
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_fact_cu.sv
// Testbench for fact_cu: a behavioural factorial datapath surrounds the
// controller, and results/timing are compared against N! and the cycle
// formulas derived directly from N.
module tb_fact_cu;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        GT_flag;
  logic        Err;
  logic        sel1, sel2, reg_load, cnt_load, cnt_en, busy, done, err;
`ifdef FACT_CU_CYCLE_CNT_EN
  logic [7:0]  cycles;
`endif

  logic [3:0]  n_in   = 4'd0;
  logic [3:0]  cnt_m  = 4'd0;
  logic [31:0] prod_m = 32'd0;
  logic [31:0] out_m;

  int checks   = 0;
  int failures = 0;

  fact_cu dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .GT_flag  (GT_flag),
    .Err      (Err),
    .sel1     (sel1),
    .sel2     (sel2),
    .reg_load (reg_load),
    .cnt_load (cnt_load),
    .cnt_en   (cnt_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef FACT_CU_CYCLE_CNT_EN
    ,
    .cycles   (cycles)
`endif
  );

  always #5 clk = ~clk;

  // Datapath environment driven by the controller outputs.
  always @(posedge clk) begin
    if (cnt_load)    cnt_m <= n_in;
    else if (cnt_en) cnt_m <= cnt_m - 4'd1;
    if (reg_load)    prod_m <= sel1 ? 32'd1 : prod_m * {28'd0, cnt_m};
  end

  assign GT_flag = (cnt_m > 4'd1);
  assign Err     = (n_in > 4'd12);
  assign out_m   = sel2 ? 32'd0 : prod_m;

  function automatic logic [31:0] fact_ref(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * 32'(i);
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request for N and follow it to done. With pulse=1, go drops
  // after the accepting edge and the return to IDLE is also checked.
  task automatic run_fact(input int n, input bit pulse);
    int  exp_busy, exp_done, first_done, busy_bad;
    bit  rej;
    rej      = (n > 12);
    exp_busy = rej ? 0 : ((n <= 1) ? 2 : 2 * n);
    exp_done = rej ? 1 : exp_busy + 1;
    n_in = 4'(n);
    go   = 1'b1;
    tick();
    if (pulse) go = 1'b0;
    first_done = 0;
    busy_bad   = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (done) begin
        first_done = cyc;
        break;
      end
      if (busy !== ((cyc <= exp_busy) ? 1'b1 : 1'b0)) busy_bad++;
      tick();
    end
    check_eq($sformatf("done_cycle_n%0d", n), 32'(first_done), 32'(exp_done));
    check_eq($sformatf("busy_profile_n%0d", n), 32'(busy_bad), 32'd0);
    check_eq($sformatf("err_n%0d", n), 32'(err), 32'(rej));
    check_eq($sformatf("out_n%0d", n), out_m, rej ? 32'd0 : fact_ref(n));
    check_eq($sformatf("busy_at_done_n%0d", n), 32'(busy), 32'd0);
`ifdef FACT_CU_CYCLE_CNT_EN
    check_eq($sformatf("cycles_n%0d", n), 32'(cycles), 32'(exp_busy));
`endif
    if (pulse) begin
      tick();
      check_eq($sformatf("idle_after_n%0d", n), 32'({done, err, busy, sel2}), 32'b0001);
    end
  endtask

  initial begin
    int hold_bad;
    reset = 1'b1;
    go    = 1'b0;
    tick();
    tick();
    check_eq("reset_outputs", 32'({sel1, sel2, reg_load, cnt_load, cnt_en, busy, done, err}), 32'h40);
`ifdef FACT_CU_CYCLE_CNT_EN
    check_eq("reset_cycles", 32'(cycles), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Directed cases, including both boundaries of the valid range.
    run_fact(5, 1'b1);
    run_fact(0, 1'b1);
    run_fact(1, 1'b1);
    run_fact(12, 1'b1);
    run_fact(13, 1'b1);
    run_fact(15, 1'b1);

    // Reset mid-computation: asserted during cycle 4, IDLE outputs in cycle 5.
    n_in = 4'd6;
    go   = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrun_reset_outputs", 32'({sel1, sel2, reg_load, cnt_load, cnt_en, busy, done, err}), 32'h40);
    tick();
    run_fact(3, 1'b1);

    // go held high through DONE: no restart, done held, then release and restart.
    run_fact(4, 1'b0);
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b1 || busy !== 1'b0) hold_bad++;
    end
    check_eq("hold_go_no_restart", 32'(hold_bad), 32'd0);
    check_eq("hold_out", out_m, 32'd24);
    go = 1'b0;
    tick();
    check_eq("release_to_idle", 32'({done, busy}), 32'b00);
    run_fact(4, 1'b1);

    // Randomized requests over the full 4-bit N range with random idle gaps.
    for (int k = 0; k < 12; k++) begin
      run_fact(int'($urandom_range(0, 15)), 1'b1);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
